// File: rtl/register_pkg.sv
// rtl/register_pkg.sv - shared defaults, data word type and address-width helper for register_file
package register_pkg;

    localparam int DEFAULT_WIDTH = 16;
    localparam int DEFAULT_DEPTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] word_t;

    // A two-entry bank still needs one address bit, which $clog2(2) already gives.
    function automatic int addr_width(input int depth);
        return (depth <= 2) ? 1 : $clog2(depth);
    endfunction

endpackage

// File: rtl/reg_cell.sv
// rtl/reg_cell.sv - one storage word with async reset, sync clear and write enable
module reg_cell #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q <= '0;
        end else if (clr) begin
            q <= '0;
        end else if (en) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// rtl/register_file.sv - WIDTH x DEPTH bank, one write and two registered read ports; REGFILE_BYPASS_EN selects write-first forwarding
module register_file
    import register_pkg::*;
#(
    parameter int WIDTH    = DEFAULT_WIDTH,
    parameter int DEPTH    = DEFAULT_DEPTH,
    parameter int ADDR_W   = addr_width(DEPTH),
    parameter int ZERO_REG = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clr,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [WIDTH-1:0]  wdata,
    input  logic              re_a,
    input  logic [ADDR_W-1:0] raddr_a,
    output logic [WIDTH-1:0]  rdata_a,
    input  logic              re_b,
    input  logic [ADDR_W-1:0] raddr_b,
    output logic [WIDTH-1:0]  rdata_b
);

    logic [WIDTH-1:0] regs [DEPTH];
    logic [DEPTH-1:0] wen;
    logic [WIDTH-1:0] sel_a;
    logic [WIDTH-1:0] sel_b;

    // Out-of-range and hardwired-zero addresses never match an enable, so those writes vanish.
    for (genvar i = 0; i < DEPTH; i++) begin : g_cell
        assign wen[i] = we && (waddr == ADDR_W'(i)) && !((ZERO_REG != 0) && (i == 0));

        reg_cell #(.WIDTH(WIDTH)) u_cell (
            .clk (clk),
            .rst (rst),
            .clr (clr),
            .en  (wen[i]),
            .d   (wdata),
            .q   (regs[i])
        );
    end

`ifdef REGFILE_BYPASS_EN
    logic write_ok;
    assign write_ok = |wen;
`endif

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!((ZERO_REG != 0) && (k == 0))) begin
                if (raddr_a == ADDR_W'(k)) sel_a = regs[k];
                if (raddr_b == ADDR_W'(k)) sel_b = regs[k];
            end
        end
`ifdef REGFILE_BYPASS_EN
        if (write_ok && (raddr_a == waddr)) sel_a = wdata;
        if (write_ok && (raddr_b == waddr)) sel_b = wdata;
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_a <= '0;
            rdata_b <= '0;
        end else begin
            if (re_a) rdata_a <= clr ? '0 : sel_a;
            if (re_b) rdata_b <= clr ? '0 : sel_b;
        end
    end

endmodule

// File: tb/tb_register_file.sv
// tb/tb_register_file.sv - scoreboard bench for register_file (DEPTH=6, ZERO_REG=1), honours REGFILE_BYPASS_EN
module tb_register_file;

    localparam int W  = 16;
    localparam int D  = 6;
    localparam int AW = 3;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
    } exp_t;

    logic          clk = 0;
    logic          rst = 1;
    logic          clr = 0;
    logic          we = 0;
    logic [AW-1:0] waddr = '0;
    logic [W-1:0]  wdata = '0;
    logic          re_a = 0;
    logic [AW-1:0] raddr_a = '0;
    logic [W-1:0]  rdata_a;
    logic          re_b = 0;
    logic [AW-1:0] raddr_b = '0;
    logic [W-1:0]  rdata_b;

    int total = 0;
    int bad = 0;

    exp_t         expq[$];
    logic [W-1:0] mem [8];
    logic [W-1:0] ma;
    logic [W-1:0] mb;

    register_file #(.WIDTH(W), .DEPTH(D), .ZERO_REG(1)) dut (
        .clk(clk), .rst(rst), .clr(clr), .we(we), .waddr(waddr), .wdata(wdata),
        .re_a(re_a), .raddr_a(raddr_a), .rdata_a(rdata_a),
        .re_b(re_b), .raddr_b(raddr_b), .rdata_b(rdata_b)
    );

    always #5 clk = ~clk;

    function automatic logic [W-1:0] peek(input int addr);
        if (addr >= D || addr == 0) return '0;
        return mem[addr];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 8; i++) mem[i] = '0;
        ma = '0;
        mb = '0;
    endtask

    task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, got, want);
        end
    endtask

    // Apply one cycle of stimulus at the falling edge and queue what the ports must show after the next rising edge.
    task automatic step(input logic c, input logic w, input int wa, input logic [W-1:0] wd,
                        input logic ea, input int ra, input logic eb, input int rb);
        bit   fwd;
        bit   wok;
        exp_t e;
        @(negedge clk);
        clr = c; we = w; waddr = AW'(wa); wdata = wd;
        re_a = ea; raddr_a = AW'(ra); re_b = eb; raddr_b = AW'(rb);
        wok = w && wa < D && wa != 0;
`ifdef REGFILE_BYPASS_EN
        fwd = 1;
`else
        fwd = 0;
`endif
        if (ea) ma = c ? '0 : (fwd && wok && ra == wa) ? wd : peek(ra);
        if (eb) mb = c ? '0 : (fwd && wok && rb == wa) ? wd : peek(rb);
        if (c) begin
            for (int i = 0; i < 8; i++) mem[i] = '0;
        end else if (wok) begin
            mem[wa] = wd;
        end
        e.a = ma;
        e.b = mb;
        expq.push_back(e);
    endtask

    task automatic idle();
        step(0, 0, 0, '0, 0, 0, 0, 0);
    endtask

    always @(posedge clk) begin
        exp_t e;
        #1;
        if (expq.size() > 0) begin
            e = expq.pop_front();
            check("rdata_a", rdata_a, e.a);
            check("rdata_b", rdata_b, e.b);
        end
    end

    initial begin
        model_reset();
        repeat (3) @(negedge clk);
        check("reset_a", rdata_a, '0);
        check("reset_b", rdata_b, '0);
        rst = 0;

        // write then read, then hold while the register is rewritten
        step(0, 1, 3, 16'h0013, 0, 0, 0, 0);
        step(0, 0, 0, '0, 1, 3, 0, 0);
        step(0, 1, 3, 16'h0031, 0, 0, 0, 0);
        idle();
        step(0, 0, 0, '0, 1, 3, 1, 3);

        // dual read
        step(0, 1, 1, 16'h0031, 0, 0, 0, 0);
        step(0, 1, 2, 16'h0001, 0, 0, 0, 0);
        step(0, 0, 0, '0, 1, 1, 1, 2);

        // read-during-write on both ports
        step(0, 1, 5, 16'h00AA, 0, 0, 0, 0);
        step(0, 1, 5, 16'h0055, 1, 5, 1, 5);
        step(0, 0, 0, '0, 1, 5, 0, 0);

        // clear beats a simultaneous write and a simultaneous read
        step(0, 1, 4, 16'h7777, 0, 0, 0, 0);
        step(1, 1, 4, 16'hFFFF, 0, 0, 1, 4);
        step(0, 0, 0, '0, 1, 4, 1, 1);
        step(0, 0, 0, '0, 1, 5, 1, 2);

        // out-of-range and hardwired-zero addresses, including forwarding attempts
        step(0, 1, 7, 16'h1234, 1, 7, 0, 0);
        step(0, 0, 0, '0, 1, 7, 1, 6);
        step(0, 1, 0, 16'hBEEF, 1, 0, 1, 0);
        step(0, 0, 0, '0, 1, 0, 1, 0);

        // async reset mid-cycle with data held in the bank
        step(0, 1, 2, 16'hA5A5, 0, 0, 0, 0);
        step(0, 0, 0, '0, 1, 2, 1, 2);
        @(negedge clk);
        we = 1; waddr = 3; wdata = 16'hC3C3; re_a = 0; re_b = 0; clr = 0;
        #2 rst = 1;
        #1;
        check("async_rst_a", rdata_a, '0);
        check("async_rst_b", rdata_b, '0);
        model_reset();
        @(negedge clk);
        we = 0;
        check("rst_held_a", rdata_a, '0);
        check("rst_held_b", rdata_b, '0);
        rst = 0;
        for (int i = 0; i < 8; i++) step(0, 0, 0, '0, 1, i, 1, 7 - i);

        for (int n = 0; n < 400; n++) begin
            step(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
                 $urandom_range(0, 7), W'($urandom),
                 $urandom_range(0, 1), $urandom_range(0, 7),
                 $urandom_range(0, 1), $urandom_range(0, 7));
        end
        idle();
        @(posedge clk);
        #2;
        total++;
        if (expq.size() != 0) begin
            bad++;
            $display("FAIL drain: %0d entries left, expected 0", expq.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/register_file.md
# register_file

Parametrised multi-register storage block for the 16-bit processor datapath; the generalisation of the single enable-controlled register into a WIDTH×DEPTH bank. Provides one synchronous write port and two independent registered read ports (A/B) for the ALU operand fetch, plus a synchronous clear-all. Sits between the decode stage (addresses, enables) and the ALU operand inputs.

## Interface
- WIDTH, 16, data width of every register
- DEPTH, 8, number of registers (≥2; need not be a power of two)
- ADDR_W, $clog2(DEPTH), address width (derived; not overridden)
- ZERO_REG, 0, when 1 register 0 is hardwired to zero

- clk  in  1  single clock, all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- clr  in  1  synchronous clear of all registers
- we  in  1  write enable
- waddr  in  ADDR_W  write address
- wdata  in  WIDTH  write data
- re_a  in  1  read enable, port A
- raddr_a  in  ADDR_W  read address, port A
- rdata_a  out  WIDTH  registered read data, port A
- re_b  in  1  read enable, port B
- raddr_b  in  ADDR_W  read address, port B
- rdata_b  out  WIDTH  registered read data, port B

## Operation
- Reset (rst=1, any time, independent of clk): all registers, rdata_a, rdata_b → 0. Reset mid-write discards the write.
- Write: on rising edge with we=1, reg[waddr] ← wdata. we=0 → contents hold.
- Write ignored when waddr ≥ DEPTH, or waddr=0 with ZERO_REG=1.
- clr=1: all registers ← 0 on the edge; clr takes priority over a simultaneous write. rdata_x updated that cycle with re_x=1 read 0.
- Read: on rising edge with re_x=1, rdata_x ← reg[raddr_x]; re_x=0 → rdata_x holds its previous value.
- raddr_x ≥ DEPTH → rdata_x ← 0. raddr_x=0 with ZERO_REG=1 → 0.
- Ports A and B independent; same address on both allowed, both return same value.
- Read-during-write (same edge, re_x=1, we=1, raddr_x=waddr, write not ignored): governed by the configuration macro below.

## Timing
- Write latency: value visible in storage after 1 edge; readable on rdata_x 2 edges after write issue (without bypass).
- Read latency: 1 cycle; address presented in cycle n → rdata_x valid after edge ending cycle n.
- No handshake; one write and two reads accepted every cycle, no stalls.
- Outputs purely registered; no combinational path from inputs to rdata_x.

## Configuration
- REGFILE_BYPASS_EN defined: read-during-write forwards — rdata_x ← wdata on that edge (write-first). clr still wins (rdata_x ← 0). Ignored writes never forward.
- Not defined: read-first — rdata_x ← old reg[raddr_x]; new value visible on next read.

## Structure
- Shared package register_pkg: default WIDTH (16), default DEPTH (8), data word typedef, ADDR_W helper function.
- One sub-module natural: reg_cell — WIDTH-bit register with async active-high rst, sync clr, and enable; instantiated DEPTH times via generate. Read muxes and bypass logic live in register_file.

## Test plan
- Reset: assert rst mid-cycle with prior data → all regs and rdata_a/rdata_b read 0 immediately and after release.
- Write/read: we=1, waddr=3, wdata=16'h0013; next cycle re_a=1, raddr_a=3 → rdata_a=16'h0013 one edge later; re_a=0 afterwards → rdata_a holds 16'h0013 while reg 3 rewritten to 16'h0031.
- Dual read: reg1=16'h0031, reg2=16'h0001; raddr_a=1, raddr_b=2 same cycle → rdata_a=16'h0031, rdata_b=16'h0001.
- Read-during-write: reg5=16'h00AA; same edge we=1, waddr=5, wdata=16'h0055, re_a=1, raddr_a=5 → rdata_a=16'h0055 with REGFILE_BYPASS_EN, 16'h00AA without.
- clr vs write: clr=1 and we=1 (waddr=4, wdata=16'hFFFF) same edge → reg 4 and all others read 0 afterwards.
- Edge addresses: DEPTH=6, write 16'h1234 to addr 7 → ignored, read addr 7 → 0; ZERO_REG=1, write 16'hBEEF to addr 0 → read addr 0 returns 0.
